mc_control_unit: RTL and testbench
==================================

# mc_control_unit

- Multicycle main controller for the 16-bit accumulator-style processor.
- Fetches and decodes each instruction and sequences the datapath through per-class state paths.
- Drives `alu_op` into the ALU control decoder; that decoder turns `alu_op` and `func` into the ALU opcode and the register-write/move strobes.
- Waits on a variable-latency memory through a ready handshake.

## Interface
Parameters:
- `OPC_W`, 4: opcode field width (`inst[15:12]`).

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: one clock; reset is asynchronous and active-low.
- `opcode` in 4: IR bits [15:12], valid from DECODE onward.
- `zero` in 1: ALU zero flag, combinational from the current cycle's ALU result.
- `mem_ready` in 1: memory has completed the current read/write this cycle.
- `mem_read` out 1: memory read request.
- `mem_write` out 1: memory write request.
- `i_or_d` out 1: memory address select; 0 = PC, 1 = `inst[11:0]`.
- `ir_write` out 1: load IR from memory data.
- `mdr_write` out 1: load MDR from memory data.
- `pc_write` out 1: unconditional PC load.
- `pc_write_cond` out 1: PC load qualified by `zero` (qualification done here, see Operation).
- `pc_src` out 2: 00 ALU result, 01 jump target `{PC[15:12],inst[11:0]}`, 10 ALUOut register.
- `alu_src_a` out 1: 0 = PC, 1 = register A (`R0`).
- `alu_src_b` out 2: 00 register B, 01 constant 1, 10 sign-extended `inst[11:0]`.
- `alu_op` out 3: 000 type-C (func-decoded), 001 add, 010 sub, 011 and, 100 or.
- `reg_write` out 1: write register file; the ALU-control strobe gates the type-C path.
- `mem_to_reg` out 1: 0 = ALUOut, 1 = MDR.
- `reg_dst` out 1: 0 = `R0`, 1 = `inst[11:9]`.

## Operation
Opcode map:
- 0000 LOAD, 0001 STORE, 0010 JUMP, 0100 BZ, 1000 TYPEC.
- 1100 ADDI, 1101 SUBI, 1110 ANDI, 1111 ORI.
- Any other opcode is a NOP and returns to FETCH.

Output rule:
- Moore outputs; every output is 0 unless asserted by the current state.
- Exceptions: `pc_write` in FETCH and `ir_write` are additionally gated by `mem_ready`.

States and behaviour:
- FETCH: `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=001, `pc_src`=00.
  - `ir_write`=`pc_write`=`mem_ready`.
  - Stays in FETCH while `mem_ready`=0; goes to DECODE when 1.
- DECODE: `alu_src_a`=0, `alu_src_b`=10, `alu_op`=001 (branch target into ALUOut). Next state by opcode:
  - LOAD→MEM_RD, STORE→MEM_WR, JUMP→JUMP, BZ→BRANCH, TYPEC→C_EXEC.
  - ADDI/SUBI/ANDI/ORI→I_EXEC.
  - Others→FETCH.
- MEM_RD: `mem_read`=1, `i_or_d`=1, `mdr_write`=`mem_ready`. Holds until `mem_ready`, then →MEM_WB.
- MEM_WB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0 →FETCH.
- MEM_WR: `mem_write`=1, `i_or_d`=1. Holds until `mem_ready`, then →FETCH.
- JUMP: `pc_write`=1, `pc_src`=01 →FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=010, `pc_src`=10, `pc_write_cond`=`zero` →FETCH.
- C_EXEC: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=000 →C_WB.
- C_WB: `alu_op`=000 (held so the ALU-control strobes stay valid), `reg_write`=1, `reg_dst`=1 →FETCH.
- I_EXEC: `alu_src_a`=1, `alu_src_b`=10; `alu_op` = 001/010/011/100 for ADDI/SUBI/ANDI/ORI →I_WB.
- I_WB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0 →FETCH.

Reset:
- Asynchronous assert forces FETCH immediately, including mid-memory-access; a pending `mem_ready` is ignored.
- On deassert, the first edge evaluates FETCH normally.

## Timing
- Reset value of every output: 0, except FETCH outputs (`mem_read`=1, `alu_src_b`=01, `alu_op`=001), which appear combinationally once the state is FETCH.
- With zero-wait memory (`mem_ready`=1 in the same cycle), cycles per instruction:
  - LOAD 4; STORE 3; JUMP 3; BZ 3.
  - TYPEC 4; immediate 4; NOP 2.
- Each wait cycle on `mem_ready` adds exactly one cycle in FETCH, MEM_RD or MEM_WR.
- The state register is the only sequential element: one 4-bit register, updated on `posedge clk`, cleared on `negedge rst_n`.

## Structure
- Shared package `mc_pkg` holds:
  - opcode localparams;
  - `alu_op` encodings (shared with the ALU control decoder);
  - `pc_src`/`alu_src_b` encodings;
  - the state enum.
- Natural split: sub-module `mc_next_state` (pure combinational next-state logic). The top keeps the state register and output decode.

## Test plan
- Reset: hold `rst_n`=0 mid-MEM_RD, then release → state FETCH, `mem_read`=1, `alu_op`=001, all write strobes 0.
- ADDI (`opcode`=1100), `mem_ready`=1 → sequence FETCH, DECODE, I_EXEC (`alu_op`=001, `alu_src_b`=10), I_WB (`reg_write`=1), FETCH: 4 cycles.
- LOAD with `mem_ready` low 3 cycles in MEM_RD → MEM_RD held 4 cycles, `mdr_write` pulses once, then MEM_WB with `mem_to_reg`=1.
- BZ with `zero`=1 → BRANCH asserts `pc_write_cond`=1, `pc_src`=10; repeat with `zero`=0 → `pc_write_cond`=0.
- TYPEC (`opcode`=1000) → `alu_op`=000 in both C_EXEC and C_WB, `reg_dst`=1 in C_WB.
- Undefined opcode 0111 → DECODE→FETCH; no write strobe asserted at any point.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: opcodes, ALU operation codes,
// mux selects and the controller state enum.
package mc_pkg;

  localparam logic [3:0] OPC_LOAD  = 4'b0000;
  localparam logic [3:0] OPC_STORE = 4'b0001;
  localparam logic [3:0] OPC_JUMP  = 4'b0010;
  localparam logic [3:0] OPC_BZ    = 4'b0100;
  localparam logic [3:0] OPC_TYPEC = 4'b1000;
  localparam logic [3:0] OPC_ADDI  = 4'b1100;
  localparam logic [3:0] OPC_SUBI  = 4'b1101;
  localparam logic [3:0] OPC_ANDI  = 4'b1110;
  localparam logic [3:0] OPC_ORI   = 4'b1111;

  localparam logic [2:0] ALU_OP_TYPEC = 3'b000;
  localparam logic [2:0] ALU_OP_ADD   = 3'b001;
  localparam logic [2:0] ALU_OP_SUB   = 3'b010;
  localparam logic [2:0] ALU_OP_AND   = 3'b011;
  localparam logic [2:0] ALU_OP_OR    = 3'b100;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b01;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b10;

  localparam logic [1:0] SRC_B_REG = 2'b00;
  localparam logic [1:0] SRC_B_ONE = 2'b01;
  localparam logic [1:0] SRC_B_IMM = 2'b10;

  // FETCH must stay at zero: the async reset clears the state register.
  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_MEM_RD  = 4'd2,
    ST_MEM_WB  = 4'd3,
    ST_MEM_WR  = 4'd4,
    ST_JUMP    = 4'd5,
    ST_BRANCH  = 4'd6,
    ST_C_EXEC  = 4'd7,
    ST_C_WB    = 4'd8,
    ST_I_EXEC  = 4'd9,
    ST_I_WB    = 4'd10
  } state_t;

  // Immediate-class opcodes share the top two bits; the low two pick the operation.
  function automatic logic [2:0] imm_alu_op(input logic [1:0] sel);
    logic [2:0] op;
    case (sel)
      2'b00:   op = ALU_OP_ADD;
      2'b01:   op = ALU_OP_SUB;
      2'b10:   op = ALU_OP_AND;
      default: op = ALU_OP_OR;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mc_next_state.sv
// Combinational next-state logic for the multicycle controller.
module mc_next_state
  import mc_pkg::*;
#(
  parameter int OPC_W = 4
) (
  input  state_t           state,
  input  logic [OPC_W-1:0] opcode,
  input  logic             mem_ready,
  output state_t           state_nxt
);

  always_comb begin
    state_nxt = ST_FETCH;
    case (state)
      ST_FETCH:  state_nxt = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (opcode)
          OPC_LOAD:  state_nxt = ST_MEM_RD;
          OPC_STORE: state_nxt = ST_MEM_WR;
          OPC_JUMP:  state_nxt = ST_JUMP;
          OPC_BZ:    state_nxt = ST_BRANCH;
          OPC_TYPEC: state_nxt = ST_C_EXEC;
          OPC_ADDI, OPC_SUBI, OPC_ANDI, OPC_ORI: state_nxt = ST_I_EXEC;
          default:   state_nxt = ST_FETCH;
        endcase
      end
      ST_MEM_RD: state_nxt = mem_ready ? ST_MEM_WB : ST_MEM_RD;
      ST_MEM_WR: state_nxt = mem_ready ? ST_FETCH : ST_MEM_WR;
      ST_C_EXEC: state_nxt = ST_C_WB;
      ST_I_EXEC: state_nxt = ST_I_WB;
      default:   state_nxt = ST_FETCH;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle main controller: state register plus Moore output decode.
//   state   | meaning
//   FETCH   | read instruction at PC, PC+1 -> PC on mem_ready
//   DECODE  | branch target into ALUOut, dispatch on opcode
//   MEM_RD  | data read at inst[11:0], MDR load on mem_ready
//   MEM_WB  | MDR -> R0
//   MEM_WR  | data write at inst[11:0] until mem_ready
//   JUMP    | PC <- {PC[15:12], inst[11:0]}
//   BRANCH  | R0 - B, PC <- ALUOut when zero
//   C_EXEC  | func-decoded ALU op on R0, B
//   C_WB    | result -> inst[11:9]
//   I_EXEC  | immediate ALU op on R0
//   I_WB    | ALUOut -> R0
module mc_control_unit
  import mc_pkg::*;
#(
  parameter int OPC_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             mdr_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             reg_dst
);

  state_t state;
  state_t state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_FETCH;
    else        state <= state_nxt;
  end

  mc_next_state #(.OPC_W(OPC_W)) u_next_state (
    .state     (state),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .state_nxt (state_nxt)
  );

  always_comb begin
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    mdr_write     = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = PC_SRC_ALU;
    alu_src_a     = 1'b0;
    alu_src_b     = SRC_B_REG;
    alu_op        = ALU_OP_TYPEC;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    case (state)
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRC_B_ONE;
        alu_op    = ALU_OP_ADD;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      ST_DECODE: begin
        alu_src_b = SRC_B_IMM;
        alu_op    = ALU_OP_ADD;
      end
      ST_MEM_RD: begin
        mem_read  = 1'b1;
        i_or_d    = 1'b1;
        mdr_write = mem_ready;
      end
      ST_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      ST_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      ST_JUMP: begin
        pc_write = 1'b1;
        pc_src   = PC_SRC_JUMP;
      end
      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_OP_SUB;
        pc_src        = PC_SRC_ALUOUT;
        pc_write_cond = zero;
      end
      ST_C_EXEC: alu_src_a = 1'b1;
      ST_C_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      ST_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
        alu_op    = imm_alu_op(opcode[1:0]);
      end
      ST_I_WB: reg_write = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench: per-instruction expected output traces built from the
// opcode map and handshake rules, compared every cycle against the controller.
module tb_mc_control_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] opcode = 4'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_read, mem_write, i_or_d, ir_write, mdr_write, pc_write, pc_write_cond;
  logic [1:0] pc_src, alu_src_b;
  logic       alu_src_a, reg_write, mem_to_reg, reg_dst;
  logic [2:0] alu_op;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       mdr_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       reg_write;
    logic       mem_to_reg;
    logic       reg_dst;
  } outs_t;

  outs_t obs;
  outs_t exp_q[$];
  bit    rdy_q[$];
  bit    zero_q[$];
  int    checks = 0;
  int    failures = 0;

  mc_control_unit #(.OPC_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
    .mdr_write(mdr_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst)
  );

  assign obs = {mem_read, mem_write, i_or_d, ir_write, mdr_write, pc_write, pc_write_cond,
                pc_src, alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, reg_dst};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%05h exp=%05h", tag, got, exp);
    end
  endtask

  function automatic outs_t fetch_o(input bit rdy);
    outs_t o = '0;
    o.mem_read  = 1'b1;
    o.alu_src_b = 2'b01;
    o.alu_op    = 3'b001;
    o.ir_write  = rdy;
    o.pc_write  = rdy;
    return o;
  endfunction

  task automatic push(input outs_t o, input bit rdy, input bit z);
    exp_q.push_back(o);
    rdy_q.push_back(rdy);
    zero_q.push_back(z);
  endtask

  // Expected cycle-by-cycle trace of one instruction, from FETCH back to FETCH.
  task automatic build(input int op, input int fw, input int mw, input bit z);
    outs_t o;
    for (int i = 0; i < fw; i++) push(fetch_o(1'b0), 1'b0, 1'($urandom));
    push(fetch_o(1'b1), 1'b1, 1'($urandom));
    o = '0; o.alu_src_b = 2'b10; o.alu_op = 3'b001;
    push(o, 1'($urandom), 1'($urandom));
    case (op)
      0: begin
        o = '0; o.mem_read = 1'b1; o.i_or_d = 1'b1;
        for (int i = 0; i < mw; i++) push(o, 1'b0, 1'($urandom));
        o.mdr_write = 1'b1;
        push(o, 1'b1, 1'($urandom));
        o = '0; o.reg_write = 1'b1; o.mem_to_reg = 1'b1;
        push(o, 1'($urandom), 1'($urandom));
      end
      1: begin
        o = '0; o.mem_write = 1'b1; o.i_or_d = 1'b1;
        for (int i = 0; i < mw; i++) push(o, 1'b0, 1'($urandom));
        push(o, 1'b1, 1'($urandom));
      end
      2: begin
        o = '0; o.pc_write = 1'b1; o.pc_src = 2'b01;
        push(o, 1'($urandom), 1'($urandom));
      end
      4: begin
        o = '0; o.alu_src_a = 1'b1; o.alu_op = 3'b010; o.pc_src = 2'b10; o.pc_write_cond = z;
        push(o, 1'($urandom), z);
      end
      8: begin
        o = '0; o.alu_src_a = 1'b1;
        push(o, 1'($urandom), 1'($urandom));
        o = '0; o.reg_write = 1'b1; o.reg_dst = 1'b1;
        push(o, 1'($urandom), 1'($urandom));
      end
      12, 13, 14, 15: begin
        o = '0; o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_op = 3'(op - 11);
        push(o, 1'($urandom), 1'($urandom));
        o = '0; o.reg_write = 1'b1;
        push(o, 1'($urandom), 1'($urandom));
      end
      default: ;
    endcase
  endtask

  // Entered and left just after a falling edge.
  task automatic run_queue(input string tag);
    outs_t e;
    int    cyc = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      mem_ready = rdy_q.pop_front();
      zero = zero_q.pop_front();
      #1;
      check($sformatf("%s_c%0d", tag, cyc), obs, e);
      cyc++;
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic run_instr(input string tag, input int op, input int fw, input int mw, input bit z);
    opcode = 4'(op);
    build(op, fw, mw, z);
    run_queue(tag);
  endtask

  initial begin
    outs_t o;
    int op, fw, mw;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_idle", obs, fetch_o(1'b0));
    @(negedge clk);

    // Get into MEM_RD waiting on memory, then reset with a ready pending.
    opcode = 4'd0;
    push(fetch_o(1'b1), 1'b1, 1'b0);
    o = '0; o.alu_src_b = 2'b10; o.alu_op = 3'b001;
    push(o, 1'b0, 1'b0);
    o = '0; o.mem_read = 1'b1; o.i_or_d = 1'b1;
    push(o, 1'b0, 1'b0);
    run_queue("pre_rst");
    mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    mem_ready = 1'b0;
    #1;
    check("rst_mid_memrd", obs, fetch_o(1'b0));
    mem_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("rst_held", obs, fetch_o(1'b0));
    rst_n = 1'b1;
    #1;
    check("rst_release", obs, fetch_o(1'b0));
    @(negedge clk);

    run_instr("addi", 12, 0, 0, 1'b0);
    run_instr("load_w3", 0, 0, 3, 1'b0);
    run_instr("bz_z1", 4, 0, 0, 1'b1);
    run_instr("bz_z0", 4, 0, 0, 1'b0);
    run_instr("typec", 8, 0, 0, 1'b0);
    run_instr("nop7", 7, 0, 0, 1'b0);
    run_instr("store_w2", 1, 1, 2, 1'b0);
    run_instr("jump", 2, 2, 0, 1'b0);
    run_instr("subi", 13, 0, 0, 1'b0);
    run_instr("andi", 14, 0, 0, 1'b0);
    run_instr("ori", 15, 0, 0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      op = int'($urandom_range(0, 15));
      fw = int'($urandom_range(0, 3));
      mw = int'($urandom_range(0, 3));
      run_instr($sformatf("rnd%0d_op%0d", n, op), op, fw, mw, 1'($urandom));
    end

    mem_ready = 1'b0;
    #1;
    check("final_fetch", obs, fetch_o(1'b0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
